high_speed_diff_32bit: RTL

//   Pipelined first-difference engine: out_diff = X[n] - X[n-1] (mod 2^WIDTH) on a stream of

---
 rtl/high_speed_diff_32bit_if.sv | 34 +++
 rtl/high_speed_diff_32bit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/high_speed_diff_32bit_if.sv
// Stream bus for the first-difference engine. It carries the sample stream
// into the engine and the difference stream back out of it.
// The master side is the sample producer and the result consumer.
// The slave side is the difference engine itself.
interface high_speed_diff_32bit_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             sync_clr;
  logic             out_valid;
  logic [WIDTH-1:0] out_diff;
  logic             out_borrow;

  modport master (
    output in_valid,
    output in_data,
    output sync_clr,
    input  out_valid,
    input  out_diff,
    input  out_borrow
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  sync_clr,
    output out_valid,
    output out_diff,
    output out_borrow
  );

endinterface

// File: rtl/high_speed_diff_32bit.sv
// Pipelined first-difference engine: out_diff = X[n] - X[n-1] mod 2^WIDTH.
// It recovers the per-cycle increments from an accumulator output stream.
//
// The subtraction is split into CHUNK-bit carry slices, with one slice
// resolved per pipeline stage. This keeps every stage down to one short carry
// chain. After each stage, the finished low result bits move forward and grow
// by one slice. The unconsumed upper operand bits also move forward and shrink
// by one slice.
//
// The pipeline has a fixed latency of 2 + WIDTH/CHUNK registers. There is no
// backpressure, and bubbles pass through unchanged.
//
// WIDTH must be a multiple of CHUNK. WIDTH/CHUNK must be at least 2.
// Reset asserts asynchronously. The system must release it synchronously to clk.
module high_speed_diff_32bit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic                    clk,
  input logic                    rst,
  high_speed_diff_32bit_if.slave bus
);

  localparam int NSTAGES = WIDTH / CHUNK;

  // Input stage registers.
  logic [WIDTH-1:0] xI_q;
  logic             vI_q;
  logic             cI_q;

  // Setup stage: minuend, inverted subtrahend, and the previous-sample register.
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;
  logic [WIDTH-1:0] sub_d;
  logic [WIDTH-1:0] xP_q;
  logic [WIDTH-1:0] nsP_q;
  logic             vP_q;

  // Output registers. These are also the register stage for the top slice.
  logic [CHUNK:0]   sumLast_d;
  logic [WIDTH-1:0] outDiff_q;
  logic             outBorrow_q;
  logic             outValid_q;

  // Capture the raw bus every cycle, so the setup logic sees a registered input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xI_q <= '0;
      vI_q <= 1'b0;
      cI_q <= 1'b0;
    end else begin
      xI_q <= bus.in_data;
      vI_q <= bus.in_valid;
      cI_q <= bus.sync_clr;
    end
  end

  // A clear forces the subtrahend to zero for this cycle. Only a valid sample
  // or a clear can change the stored previous sample.
  always_comb begin
    sub_d  = cI_q ? '0 : prev_q;
    prev_d = vI_q ? xI_q : sub_d;
  end

  // Register the operands for the carry pipeline, and update the previous sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      xP_q   <= '0;
      nsP_q  <= '0;
      vP_q   <= 1'b0;
    end else begin
      prev_q <= prev_d;
      xP_q   <= xI_q;
      nsP_q  <= ~sub_d;
      vP_q   <= vI_q;
    end
  end

  genvar k;
  for (k = 1; k < NSTAGES; k++) begin : g_stage
    localparam int DONE = CHUNK * k;
    localparam int REM  = WIDTH - DONE;

    logic [DONE-1:0] res_q;
    logic [REM-1:0]  m_q;
    logic [REM-1:0]  s_q;
    logic            cy_q;
    logic            v_q;
    logic [CHUNK:0]  sum_d;

    if (k == 1) begin : g_head
      // The lowest slice starts the two's-complement subtract with a carry-in of 1.
      assign sum_d = {1'b0, xP_q[CHUNK-1:0]} + {1'b0, nsP_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, 1'b1};

      // Keep the finished lowest slice. Pass the remaining upper operand bits forward.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_q <= '0;
          m_q   <= '0;
          s_q   <= '0;
          cy_q  <= 1'b0;
          v_q   <= 1'b0;
        end else begin
          res_q <= sum_d[CHUNK-1:0];
          m_q   <= xP_q[WIDTH-1:CHUNK];
          s_q   <= nsP_q[WIDTH-1:CHUNK];
          cy_q  <= sum_d[CHUNK];
          v_q   <= vP_q;
        end
      end
    end else begin : g_body
      // Resolve the next slice, using the carry registered by the stage before it.
      assign sum_d = {1'b0, g_stage[k-1].m_q[CHUNK-1:0]}
                   + {1'b0, g_stage[k-1].s_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, g_stage[k-1].cy_q};

      // Add this slice above the finished bits. Drop it from the remaining operands.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_q <= '0;
          m_q   <= '0;
          s_q   <= '0;
          cy_q  <= 1'b0;
          v_q   <= 1'b0;
        end else begin
          res_q <= {sum_d[CHUNK-1:0], g_stage[k-1].res_q};
          m_q   <= g_stage[k-1].m_q[REM+CHUNK-1:CHUNK];
          s_q   <= g_stage[k-1].s_q[REM+CHUNK-1:CHUNK];
          cy_q  <= sum_d[CHUNK];
          v_q   <= g_stage[k-1].v_q;
        end
      end
    end
  end

  // The top slice is resolved straight into the output registers.
  assign sumLast_d = {1'b0, g_stage[NSTAGES-1].m_q}
                   + {1'b0, g_stage[NSTAGES-1].s_q}
                   + {{CHUNK{1'b0}}, g_stage[NSTAGES-1].cy_q};

  // Outputs change only for a valid sample and hold through bubbles.
  // A missing final carry means the subtract wrapped around.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q  <= 1'b0;
      outDiff_q   <= '0;
      outBorrow_q <= 1'b0;
    end else begin
      outValid_q <= g_stage[NSTAGES-1].v_q;
      if (g_stage[NSTAGES-1].v_q) begin
        outDiff_q   <= {sumLast_d[CHUNK-1:0], g_stage[NSTAGES-1].res_q};
        outBorrow_q <= ~sumLast_d[CHUNK];
      end
    end
  end

  assign bus.out_valid  = outValid_q;
  assign bus.out_diff   = outDiff_q;
  assign bus.out_borrow = outBorrow_q;

endmodule
